// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single data-memory port between the instruction fetch unit
//   (IFU, read-only) and the load/store unit (LSU, read/write). One
//   transaction is in flight at a time: IDLE -> REQ -> RESP -> IDLE.
//   The LSU normally wins a contested grant. The IFU is forced to win once
//   the LSU has taken MAX_LSU_STREAK contested grants in a row. A response
//   timer aborts a transaction that stalls in REQ/RESP, so that a requester
//   never waits forever.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ifu_req_*/ifu_addr       IFU read request (valid/ready handshake)
//   ifu_resp_valid/rdata     IFU one-cycle response strobe and data
//   lsu_req_*/lsu_addr/...   LSU load/store request (valid/ready handshake)
//   lsu_resp_valid/rdata     LSU one-cycle response strobe and data
//   mem_req_*/mem_*          latched request towards memory
//   mem_resp_valid/rdata     memory response (read data or write ack)
//   bus_err                  pulses together with a timeout-aborted response
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned MAX_LSU_STREAK = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ifu_req_valid,
   output logic        ifu_req_ready,
   input  logic [31:0] ifu_addr,
   output logic        ifu_resp_valid,
   output logic [31:0] ifu_rdata,
   input  logic        lsu_req_valid,
   output logic        lsu_req_ready,
   input  logic [31:0] lsu_addr,
   input  logic        lsu_wen,
   input  logic [31:0] lsu_wdata,
   input  logic [7:0]  lsu_wmask,
   output logic        lsu_resp_valid,
   output logic [31:0] lsu_rdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_rdata,
   output logic        bus_err
);

   localparam int unsigned SW = (MAX_LSU_STREAK > 0) ? $clog2(MAX_LSU_STREAK + 1) : 1;
   localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);
   localparam logic [TW-1:0] TIMER_LIM  = TW'(TIMEOUT_CYCLES);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic OWNER_IFU = 1'b0;
   localparam logic OWNER_LSU = 1'b1;

   logic [1:0]    state_q,  state_d;
   logic          owner_q,  owner_d;
   logic [SW-1:0] streak_q, streak_d;
   logic [TW-1:0] timer_q,  timer_d;
   logic [31:0]   addr_q,   addr_d;
   logic          wen_q,    wen_d;
   logic [31:0]   wdata_q,  wdata_d;
   logic [7:0]    wmask_q,  wmask_d;

   logic          timeout_s;
   logic          resp_s;
   logic [31:0]   rdata_s;
   logic          bus_err_s;
   logic          ifu_ready_s;
   logic          lsu_ready_s;
   logic          grant_lsu_s;
   logic          grant_ifu_s;

   // A zero limit disables the timeout entirely.
   assign timeout_s = (TIMEOUT_CYCLES != 0) && (timer_q == TIMER_LIM);

   // Arbitration, FSM next state and response steering.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      streak_d    = streak_q;
      timer_d     = timer_q;
      addr_d      = addr_q;
      wen_d       = wen_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      resp_s      = 1'b0;
      rdata_s     = 32'h0000_0000;
      bus_err_s   = 1'b0;
      ifu_ready_s = 1'b0;
      lsu_ready_s = 1'b0;
      grant_lsu_s = 1'b0;
      grant_ifu_s = 1'b0;
      if (rst) begin
         // Outputs stay quiet while reset is asserted; registers reset below.
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               timer_d     = {TW{1'b0}};
               grant_lsu_s = lsu_req_valid && (!ifu_req_valid || (streak_q != STREAK_MAX));
               grant_ifu_s = ifu_req_valid && !grant_lsu_s;
               if (grant_lsu_s) begin
                  lsu_ready_s = 1'b1;
                  owner_d     = OWNER_LSU;
                  addr_d      = lsu_addr;
                  wen_d       = lsu_wen;
                  wdata_d     = lsu_wdata;
                  wmask_d     = lsu_wmask;
                  state_d     = ST_REQ;
                  // Only contested LSU wins count towards IFU starvation.
                  if (ifu_req_valid && (streak_q != STREAK_MAX)) begin
                     streak_d = streak_q + SW'(1);
                  end else begin
                     streak_d = streak_q;
                  end
               end else if (grant_ifu_s) begin
                  ifu_ready_s = 1'b1;
                  owner_d     = OWNER_IFU;
                  addr_d      = ifu_addr;
                  wen_d       = 1'b0;
                  wdata_d     = 32'h0000_0000;
                  wmask_d     = 8'h00;
                  streak_d    = {SW{1'b0}};
                  state_d     = ST_REQ;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_REQ: begin
               if (timeout_s) begin
                  resp_s    = 1'b1;
                  bus_err_s = 1'b1;
                  state_d   = ST_IDLE;
               end else if (mem_req_ready) begin
                  timer_d = timer_q + TW'(1);
                  state_d = ST_RESP;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            ST_RESP: begin
               // A real response beats a timeout landing in the same cycle.
               if (mem_resp_valid) begin
                  resp_s  = 1'b1;
                  rdata_s = mem_rdata;
                  state_d = ST_IDLE;
               end else if (timeout_s) begin
                  resp_s    = 1'b1;
                  bus_err_s = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and request-latch registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         owner_q  <= OWNER_IFU;
         streak_q <= {SW{1'b0}};
         timer_q  <= {TW{1'b0}};
         addr_q   <= 32'h0000_0000;
         wen_q    <= 1'b0;
         wdata_q  <= 32'h0000_0000;
         wmask_q  <= 8'h00;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         streak_q <= streak_d;
         timer_q  <= timer_d;
         addr_q   <= addr_d;
         wen_q    <= wen_d;
         wdata_q  <= wdata_d;
         wmask_q  <= wmask_d;
      end
   end

   assign ifu_req_ready  = ifu_ready_s;
   assign lsu_req_ready  = lsu_ready_s;
   assign ifu_resp_valid = resp_s && (owner_q == OWNER_IFU);
   assign lsu_resp_valid = resp_s && (owner_q == OWNER_LSU);
   assign ifu_rdata      = (owner_q == OWNER_IFU) ? rdata_s : 32'h0000_0000;
   assign lsu_rdata      = (owner_q == OWNER_LSU) ? rdata_s : 32'h0000_0000;
   assign bus_err        = bus_err_s;
   assign mem_req_valid  = !rst && (state_q == ST_REQ);
   assign mem_addr       = addr_q;
   assign mem_wen        = wen_q;
   assign mem_wdata      = wdata_q;
   assign mem_wmask      = wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Two instances share every input:
//   dut uses the default timeout, dut_to uses an 8-cycle timeout and is only
//   inspected by the timeout scenario.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid;
   logic [31:0] ifu_addr;
   logic        lsu_req_valid;
   logic [31:0] lsu_addr;
   logic        lsu_wen;
   logic [31:0] lsu_wdata;
   logic [7:0]  lsu_wmask;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;

   logic        ifu_req_ready,  ifu_resp_valid, lsu_req_ready, lsu_resp_valid;
   logic [31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
   logic        mem_req_valid, mem_wen, bus_err;
   logic [7:0]  mem_wmask;

   logic        ifu_req_ready_t, ifu_resp_valid_t, lsu_req_ready_t, lsu_resp_valid_t;
   logic [31:0] ifu_rdata_t, lsu_rdata_t, mem_addr_t, mem_wdata_t;
   logic        mem_req_valid_t, mem_wen_t, bus_err_t;
   logic [7:0]  mem_wmask_t;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MAX_LSU_STREAK(4), .TIMEOUT_CYCLES(255)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .bus_err(bus_err)
   );

   mem_port_arbiter #(.MAX_LSU_STREAK(4), .TIMEOUT_CYCLES(8)) dut_to (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready_t), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid_t), .ifu_rdata(ifu_rdata_t),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready_t), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid_t), .lsu_rdata(lsu_rdata_t),
      .mem_req_valid(mem_req_valid_t), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr_t),
      .mem_wen(mem_wen_t), .mem_wdata(mem_wdata_t), .mem_wmask(mem_wmask_t),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .bus_err(bus_err_t)
   );

   // Count one comparison and report it if it does not match.
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ifu_req_valid  = 1'b0;
      ifu_addr       = 32'h0000_0000;
      lsu_req_valid  = 1'b0;
      lsu_addr       = 32'h0000_0000;
      lsu_wen        = 1'b0;
      lsu_wdata      = 32'h0000_0000;
      lsu_wmask      = 8'h00;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_rdata      = 32'h0000_0000;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // From a REQ cycle: accept the request, then return one response.
   task automatic complete(input string tag, input logic exp_ifu, input logic [31:0] rd);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = rd;
      #1;
      chk({tag, "_resp"}, {ifu_resp_valid, lsu_resp_valid, bus_err}, {exp_ifu, !exp_ifu, 1'b0});
      chk({tag, "_rdata"}, exp_ifu ? ifu_rdata : lsu_rdata, rd);
      tick();
      mem_resp_valid = 1'b0;
      mem_rdata      = 32'h0000_0000;
   endtask

   logic exp_grant [10];
   int   grants;
   int   fired;

   initial begin
      // ---- reset state ----
      rst = 1'b1;
      idle_inputs();
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      tick();
      tick();
      #1;
      chk("rst_ready", {ifu_req_ready, lsu_req_ready, mem_req_valid}, 3'b000);
      idle_inputs();
      rst = 1'b0;
      #1;
      chk("rst_out_a", {ifu_resp_valid, lsu_resp_valid, bus_err, mem_wen, mem_wmask}, 12'h000);
      chk("rst_out_b", {mem_addr, mem_wdata}, 64'h0);
      chk("rst_rdata", {ifu_rdata, lsu_rdata}, 64'h0);

      // ---- 1: IFU-only read ----
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0000;
      #1;
      chk("t1_ready", {ifu_req_ready, lsu_req_ready}, 2'b10);
      tick();
      ifu_req_valid = 1'b0;
      #1;
      chk("t1_mreq", {mem_req_valid, mem_wen, mem_addr}, {1'b1, 1'b0, 32'h8000_0000});
      complete("t1", 1'b1, 32'h0000_0413);
      chk("t1_idle", {ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 3'b000);

      // ---- 2: contested, LSU store first then IFU ----
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0004;
      lsu_req_valid = 1'b1;
      lsu_addr      = 32'h8000_1000;
      lsu_wen       = 1'b1;
      lsu_wdata     = 32'hDEAD_BEEF;
      lsu_wmask     = 8'h0F;
      #1;
      chk("t2_ready", {ifu_req_ready, lsu_req_ready}, 2'b01);
      tick();
      lsu_req_valid = 1'b0;
      lsu_wen       = 1'b0;
      #1;
      chk("t2_addr", {mem_req_valid, mem_addr}, {1'b1, 32'h8000_1000});
      chk("t2_fields", {mem_wen, mem_wdata, mem_wmask}, {1'b1, 32'hDEAD_BEEF, 8'h0F});
      chk("t2_busy", {ifu_req_ready, lsu_req_ready}, 2'b00);
      complete("t2_st", 1'b0, 32'h0000_0000);
      chk("t2_ifu_next", ifu_req_ready, 1'b1);
      tick();
      ifu_req_valid = 1'b0;
      #1;
      chk("t2_ifu_fields", {mem_addr, mem_wen, mem_wmask}, {32'h8000_0004, 1'b0, 8'h00});
      chk("t2_ifu_wdata", mem_wdata, 32'h0);
      complete("t2_ld", 1'b1, 32'h1234_5678);

      // ---- 3: streak limit, both held valid ----
      do_reset();
      exp_grant = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      ifu_req_valid  = 1'b1;
      ifu_addr       = 32'h8000_0100;
      lsu_req_valid  = 1'b1;
      lsu_addr       = 32'h8000_2100;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b1;
      grants = 0;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (ifu_req_ready || lsu_req_ready) begin
            chk("t3_excl", ifu_req_ready && lsu_req_ready, 1'b0);
            chk($sformatf("t3_grant%0d", grants), lsu_req_ready, exp_grant[grants]);
            grants++;
         end
         tick();
         if (grants == 10) break;
      end
      chk("t3_count", grants, 10);
      idle_inputs();

      // ---- 4: stall in REQ keeps fields stable ----
      do_reset();
      lsu_req_valid = 1'b1;
      lsu_addr      = 32'h8000_2000;
      lsu_wen       = 1'b0;
      lsu_wdata     = 32'h0BAD_F00D;
      #1;
      chk("t4_ready", lsu_req_ready, 1'b1);
      tick();
      lsu_req_valid = 1'b0;
      lsu_addr      = 32'hFFFF_FFFC;
      lsu_wen       = 1'b1;
      lsu_wmask     = 8'hFF;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk($sformatf("t4_hold%0d", c), {mem_req_valid, mem_wen, mem_wmask, mem_addr},
             {1'b1, 1'b0, 8'h00, 32'h8000_2000});
         tick();
      end
      lsu_wen = 1'b0;
      complete("t4", 1'b0, 32'hCAFE_0001);

      // ---- 5: timeout (8-cycle instance) ----
      do_reset();
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0010;
      mem_rdata     = 32'hFFFF_FFFF;
      #1;
      chk("t5_ready", ifu_req_ready_t, 1'b1);
      tick();
      ifu_req_valid = 1'b0;
      fired = 0;
      for (int c = 1; c <= 20; c++) begin
         mem_req_ready = (c == 1);
         #1;
         if (ifu_resp_valid_t) begin
            fired = c;
            chk("t5_abort", {bus_err_t, lsu_resp_valid_t, ifu_rdata_t}, {1'b1, 1'b0, 32'h0});
         end else begin
            chk($sformatf("t5_quiet%0d", c), bus_err_t, 1'b0);
         end
         tick();
         if (fired != 0) break;
      end
      mem_req_ready = 1'b0;
      chk("t5_when", (fired == 8) || (fired == 9), 1'b1);
      #1;
      chk("t5_after", {ifu_resp_valid_t, bus_err_t, mem_req_valid_t}, 3'b000);

      // ---- 6: reset in RESP, late memory response ignored ----
      do_reset();
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0040;
      tick();
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready  = 1'b0;
      rst            = 1'b1;
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'h0000_1234;
      #1;
      chk("t6_rst_resp", {ifu_resp_valid, lsu_resp_valid, bus_err}, 3'b000);
      tick();
      rst = 1'b0;
      #1;
      chk("t6_late", {ifu_resp_valid, lsu_resp_valid, bus_err, mem_req_valid}, 4'b0000);
      chk("t6_latch", {mem_addr, mem_wmask, mem_wen}, 41'h0);
      tick();
      mem_resp_valid = 1'b0;
      ifu_req_valid  = 1'b1;
      ifu_addr       = 32'h8000_0020;
      #1;
      chk("t6_regrant", ifu_req_ready, 1'b1);
      tick();
      ifu_req_valid = 1'b0;
      #1;
      chk("t6_addr", mem_addr, 32'h8000_0020);
      complete("t6", 1'b1, 32'h0000_0055);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
